// File: rtl/bcd_stopwatch_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_pkg
//  Description : Shared constants, mode encodings and helpers for the BCD
//                stopwatch/timer block.
//  Revision    : 1.0  initial release
// ============================================================================
package bcd_pkg;

    localparam int         BCD_W   = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    // Operating modes, sampled at reset only
    typedef enum logic [1:0] {
        MODE_SW     = 2'd0,   // stopwatch from zero
        MODE_SW_LD  = 2'd1,   // stopwatch from loaded value
        MODE_TMR    = 2'd2,   // timer from all-nines
        MODE_TMR_LD = 2'd3    // timer from loaded value
    } mode_e;

    // Non-BCD nibbles are forced to the largest legal digit
    function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] v);
        return (v > BCD_MAX) ? BCD_MAX : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_stopwatch_timer_if.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_stopwatch_timer_if
//  Description : Control/status bundle of the BCD stopwatch/timer. The lap
//                strobe and lap_digits exist only when LAP_CAPTURE_EN is
//                defined.
//  Revision    : 1.0  initial release
// ============================================================================
interface bcd_stopwatch_timer_if #(
    parameter int NUM_DIGITS  = 4,
    parameter int LOAD_DIGITS = 2
);
    logic                      cnt;
    logic [1:0]                mode;
    logic [4*LOAD_DIGITS-1:0]  load_digits;
    logic [4*NUM_DIGITS-1:0]   digits;
    logic                      running;
    logic                      done;
`ifdef LAP_CAPTURE_EN
    logic                      lap;
    logic [4*NUM_DIGITS-1:0]   lap_digits;

    modport master (output cnt, mode, load_digits, lap,
                    input  digits, lap_digits, running, done);
    modport slave  (input  cnt, mode, load_digits, lap,
                    output digits, lap_digits, running, done);
`else
    modport master (output cnt, mode, load_digits,
                    input  digits, running, done);
    modport slave  (input  cnt, mode, load_digits,
                    output digits, running, done);
`endif
endinterface
`default_nettype wire

// File: rtl/bcd_stopwatch_timer_digit.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit
//  Description : One BCD digit with up/down select, ripple carry/borrow in and
//                out, and a reset-time load value. o_co is the pure ripple
//                (ignores i_hold) so the chain end flags a terminal value.
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_digit
    import bcd_pkg::*;
(
    input  wire               clk,
    input  wire               reset,      // synchronous, active-low
    input  wire  [BCD_W-1:0]  i_load_val,
    input  wire               i_dec,
    input  wire               i_ci,
    input  wire               i_hold,
    output logic [BCD_W-1:0]  o_q,
    output logic [BCD_W-1:0]  o_nxt,
    output logic              o_co
);

    logic [BCD_W-1:0] r_q;
    logic [BCD_W-1:0] w_step;
    logic             w_en;

    // Value this digit takes when stepped once
    always_comb begin
        w_step = r_q;
        if (i_dec) begin
            w_step = (r_q == 4'd0) ? BCD_MAX : r_q - 4'd1;
        end else begin
            w_step = (r_q >= BCD_MAX) ? 4'd0 : r_q + 4'd1;
        end
    end

    assign w_en  = i_ci & ~i_hold;
    assign o_nxt = w_en ? w_step : r_q;
    assign o_co  = i_ci & (i_dec ? (r_q == 4'd0) : (r_q == BCD_MAX));
    assign o_q   = r_q;

    // Load on reset, otherwise step when enabled
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_q <= i_load_val;
        end else if (w_en) begin
            r_q <= w_step;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bcd_stopwatch_timer.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_stopwatch_timer
//  Description : Parametrised BCD stopwatch/timer with prescaled tick,
//                loadable upper digits, sticky done and saturation.
//                Optional lap capture register enabled by LAP_CAPTURE_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_stopwatch_timer
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int LOAD_DIGITS = 2,
    parameter int TICK_DIV    = 1
)(
    input wire                    clk,
    input wire                    reset,   // synchronous, active-low
    bcd_stopwatch_timer_if.slave  bus
);

    localparam int c_LO   = NUM_DIGITS - LOAD_DIGITS;
    localparam int c_PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_PS_W-1:0] c_PS_MAX = c_PS_W'(TICK_DIV - 1);
    localparam logic [4*NUM_DIGITS-1:0] c_ALL_NINES = {NUM_DIGITS{BCD_MAX}};

    mode_e                   r_mode;
    logic                    r_done;
    logic [c_PS_W-1:0]       r_ps;

    mode_e                   w_mode_in;
    logic                    w_use_load;
    logic                    w_running;
    logic                    w_tick;
    logic                    w_dec;
    logic                    w_at_term;
    logic                    w_next_term;
    logic [NUM_DIGITS:0]     w_carry;
    logic [4*NUM_DIGITS-1:0] w_q;
    logic [4*NUM_DIGITS-1:0] w_nxt;

    assign w_mode_in  = mode_e'(bus.mode);
    assign w_use_load = (w_mode_in == MODE_SW_LD) || (w_mode_in == MODE_TMR_LD);
    assign w_running  = bus.cnt & ~r_done;
    assign w_tick     = w_running & (r_ps == c_PS_MAX);
    assign w_dec      = (r_mode == MODE_TMR) || (r_mode == MODE_TMR_LD);

    // A full ripple through every digit means the count is already terminal
    assign w_carry[0]  = w_tick;
    assign w_at_term   = w_carry[NUM_DIGITS];
    assign w_next_term = w_dec ? (w_nxt == '0) : (w_nxt == c_ALL_NINES);

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        logic [BCD_W-1:0] w_ld;
        if (i >= c_LO) begin : g_loadable
            assign w_ld = w_use_load ? bcd_clamp(bus.load_digits[(i-c_LO)*BCD_W +: BCD_W])
                        : ((w_mode_in == MODE_TMR) ? BCD_MAX : 4'd0);
        end else begin : g_fixed
            assign w_ld = (w_mode_in == MODE_TMR) ? BCD_MAX : 4'd0;
        end

        bcd_digit u_digit (
            .clk        (clk),
            .reset      (reset),
            .i_load_val (w_ld),
            .i_dec      (w_dec),
            .i_ci       (w_carry[i]),
            .i_hold     (w_at_term),
            .o_q        (w_q[i*BCD_W +: BCD_W]),
            .o_nxt      (w_nxt[i*BCD_W +: BCD_W]),
            .o_co       (w_carry[i+1])
        );
    end

    // Mode latch, prescaler and sticky done flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_mode <= w_mode_in;
            r_ps   <= '0;
            r_done <= 1'b0;
        end else begin
            if (w_running) begin
                r_ps <= (r_ps == c_PS_MAX) ? '0 : r_ps + 1'b1;
            end
            if (w_tick && (w_at_term || w_next_term)) begin
                r_done <= 1'b1;
            end
        end
    end

`ifdef LAP_CAPTURE_EN
    logic [4*NUM_DIGITS-1:0] r_lap;

    // Capture the pre-step count on a lap strobe
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_lap <= '0;
        end else if (bus.lap) begin
            r_lap <= w_q;
        end
    end

    assign bus.lap_digits = r_lap;
`endif

    assign bus.digits  = w_q;
    assign bus.running = w_running;
    assign bus.done    = r_done;

endmodule
`default_nettype wire
